uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 inserts a parity bit, 0 omits it.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port clock, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tx_data, input, 8 bits: byte to send.
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-008 SHALL have port tx_ready, output, 1 bit: block can accept a byte.
REQ-009 SHALL have port tx_serial, output, 1 bit: serial line, idle high, registered.
REQ-010 SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal NOT tx_ready.
REQ-014 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - On that edge tx_data SHALL be latched into an internal shift register.
  - On that edge the parity bit SHALL be computed as the XOR of the 8 bits, inverted when PARITY_ODD=1.
  - The state SHALL move to START on the same edge.
REQ-015 tx_valid SHALL be ignored when tx_ready=0; tx_data changes after acceptance SHALL not affect the frame in progress.
REQ-016 START SHALL drive tx_serial=0 for exactly CLKS_PER_BIT cycles, then move to DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each bit for exactly CLKS_PER_BIT cycles.
  - An internal bit index 0..7 SHALL advance at each bit boundary.
  - After bit 7, the state SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-018 PARITY SHALL drive the latched parity bit for CLKS_PER_BIT cycles, then move to STOP.
REQ-019 STOP SHALL drive tx_serial=1 for CLKS_PER_BIT cycles.
  - tx_done SHALL be 1 during the last STOP cycle only.
  - The state SHALL then return to IDLE.
REQ-020 tx_serial SHALL be registered so that every line transition aligns to a clock edge.
  - tx_serial SHALL go low on the first clock edge after acceptance.
REQ-021 IDLE SHALL last at least one cycle between frames.
  - With tx_valid held high, frames SHALL be spaced (11 if PARITY_EN else 10)*CLKS_PER_BIT+1 cycles apart.
REQ-022 The bit-timer counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
  - It SHALL be held at 0 in IDLE.
  - Its width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-023 On reset_n=0, the following SHALL take effect asynchronously: state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame, with no further bits sent.
  - After reset_n rises, the first accepted byte SHALL start a fresh frame.

Structure
REQ-025 State encoding (3 bits), DATA_BITS=8 and shared UART constants SHALL live in package uart_pkg, shared with the receive side.
REQ-026 The bit timer SHALL be sub-module uart_bit_timer, with inputs clock, reset_n, enable and output bit_end.
  - uart_bit_timer SHALL be reused by the receive path.

Verification
REQ-027 With CLKS_PER_BIT=16, PARITY_EN=1, even parity, send 0xA5, then check:
  - tx_serial sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 16 cycles (parity bit 0).
  - tx_done pulses at cycle 176 after acceptance.
REQ-028 Send 0x01 with even parity -> parity bit 1; repeat with PARITY_ODD=1 -> parity bit 0.
REQ-029 With PARITY_EN=0, send 0xFF -> 10-bit frame 0,1,1,1,1,1,1,1,1,1, lasting 160 cycles.
REQ-030 Hold tx_valid=1 with 0x3C, then 0xC3 -> second START begins exactly 177 cycles after the first.
  - tx_valid pulses while busy SHALL be ignored, with tx_data unchanged in the frame.
REQ-031 Assert reset_n=0 during DATA bit 3 of 0x5A -> tx_serial=1 and tx_ready=1 immediately.
  - After release, sending 0x81 SHALL produce a correct complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Contents: frame state encoding, data width, line-level constants and a
// parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmit and receive paths.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps at each bit boundary;
// held at 0 while disabled.
// Ports:
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   enable  - run the timer; low clears it to 0
//   bit_end - high during the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic bit_end
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one stop bit. The serial line is registered, so it follows the frame
// state by one clock.
// Ports:
//   clock     - system clock
//   reset_n   - asynchronous active-low reset
//   tx_data   - byte to send, sampled on acceptance
//   tx_valid  - tx_data is offered
//   tx_ready  - transmitter idle, a byte may be accepted
//   tx_serial - serial output, idle high
//   tx_busy   - a frame is in progress
//   tx_done   - one-cycle pulse in the last stop-bit cycle
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | sending the start bit (0)
// DATA   | sending data bits, LSB first
// PARITY | sending the latched parity bit
// STOP   | sending the stop bit (1)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 parity_q,  parity_d;
    logic                 serial_q,  serial_d;
    logic                 timer_en;
    logic                 bit_end;

    assign timer_en = (state_q != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (timer_en),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = calc_parity(tx_data, PARITY_ODD != 0);
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the current state and registered, which
    // keeps every edge of tx_serial on a clock edge.
    always_comb begin
        serial_d = LINE_IDLE;
        case (state_q)
            START:   serial_d = START_BIT;
            DATA:    serial_d = shift_q[0];
            PARITY:  serial_d = parity_q;
            STOP:    serial_d = STOP_BIT;
            default: serial_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            serial_q  <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = ~tx_ready;
    assign tx_done   = (state_q == STOP) && bit_end;
    assign tx_serial = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int N_DUT = 4;
    localparam int CPB  [N_DUT] = '{16, 5, 16, 2};
    localparam int PEN  [N_DUT] = '{1, 1, 0, 1};
    localparam int PODD [N_DUT] = '{0, 1, 0, 0};

    logic             clock = 1'b0;
    logic             reset_n;
    logic [7:0]       tx_data [N_DUT];
    logic [N_DUT-1:0] tx_valid;
    logic [N_DUT-1:0] tx_ready;
    logic [N_DUT-1:0] tx_serial;
    logic [N_DUT-1:0] tx_busy;
    logic [N_DUT-1:0] tx_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_serial(tx_serial[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_serial(tx_serial[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_serial(tx_serial[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_serial(tx_serial[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int frame_bits(input int k);
        return (PEN[k] != 0) ? 11 : 10;
    endfunction

    // Reference line level for bit slot idx of a frame carrying byte b.
    function automatic logic exp_bit(input int k, input logic [7:0] b, input int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PEN[k] != 0 && idx == 9) return ((ones % 2) == 1) ^ (PODD[k] != 0);
        return 1'b1;
    endfunction

    task automatic idle_check(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tx_valid[k] = 1'b0;
            tick();
            check($sformatf("dut%0d_idle_serial", k), tx_serial[k], 1);
            check($sformatf("dut%0d_idle_ready", k), tx_ready[k], 1);
            check($sformatf("dut%0d_idle_busy", k), tx_busy[k], 0);
            check($sformatf("dut%0d_idle_done", k), tx_done[k], 0);
        end
    endtask

    // Offers byte b (caller guarantees the DUT is idle or about to be), then
    // checks every cycle of the frame. While busy, tx_valid/tx_data are
    // scrambled; at frame end they are set to keep_valid/next_b.
    task automatic send(input int k, input logic [7:0] b, input bit keep_valid,
                        input logic [7:0] next_b, input int abort_n, output int fall_cyc);
        int   len;
        logic prev;
        len      = frame_bits(k) * CPB[k];
        fall_cyc = -1;
        tx_data[k]  = b;
        tx_valid[k] = 1'b1;
        tick();
        check($sformatf("dut%0d_accept_ready", k), tx_ready[k], 0);
        check($sformatf("dut%0d_accept_busy", k), tx_busy[k], 1);
        check($sformatf("dut%0d_accept_serial", k), tx_serial[k], 1);
        prev = tx_serial[k];
        for (int n = 1; n <= len; n++) begin
            tx_valid[k] = 1'($urandom_range(0, 1));
            tx_data[k]  = 8'($urandom);
            if (n == len) begin
                tx_valid[k] = keep_valid;
                tx_data[k]  = next_b;
            end
            tick();
            check($sformatf("dut%0d_b%02h_serial_n%0d", k, b, n), tx_serial[k],
                  exp_bit(k, b, (n - 1) / CPB[k]));
            check($sformatf("dut%0d_b%02h_done_n%0d", k, b, n), tx_done[k], (n == len - 1) ? 1 : 0);
            check($sformatf("dut%0d_b%02h_ready_n%0d", k, b, n), tx_ready[k], (n == len) ? 1 : 0);
            check($sformatf("dut%0d_b%02h_busy_n%0d", k, b, n), tx_busy[k], (n == len) ? 0 : 1);
            if (prev && !tx_serial[k] && fall_cyc < 0) fall_cyc = cyc;
            prev = tx_serial[k];
            if (n == abort_n) break;
        end
        if (abort_n > 0) begin
            tx_valid[k] = 1'b0;
            reset_n = 1'b0;
            #1;
            check("abort_serial", tx_serial[k], 1);
            check("abort_ready", tx_ready[k], 1);
            check("abort_busy", tx_busy[k], 0);
            check("abort_done", tx_done[k], 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("abort_hold_serial", tx_serial[k], 1);
            end
            reset_n = 1'b1;
        end
    endtask

    initial begin
        int         f1, f2;
        logic [7:0] b, nb;
        bit         kv;

        reset_n = 1'b1;
        for (int k = 0; k < N_DUT; k++) begin
            tx_data[k]  = 8'h00;
            tx_valid[k] = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("dut%0d_rst_serial", k), tx_serial[k], 1);
            check($sformatf("dut%0d_rst_ready", k), tx_ready[k], 1);
            check($sformatf("dut%0d_rst_busy", k), tx_busy[k], 0);
            check($sformatf("dut%0d_rst_done", k), tx_done[k], 0);
        end
        tick();
        tick();
        reset_n = 1'b1;
        idle_check(0, 2);

        // 0xA5, even parity: 0,1,0,1,0,0,1,0,1,0,1 with done at the last stop cycle.
        send(0, 8'hA5, 1'b0, 8'h00, 0, f1);
        idle_check(0, 2);

        // 0x01: parity 1 when even, 0 when odd.
        send(0, 8'h01, 1'b0, 8'h00, 0, f1);
        idle_check(0, 1);
        send(1, 8'h01, 1'b0, 8'h00, 0, f1);
        idle_check(1, 1);

        // No parity: 0xFF gives a 10-bit, 160-cycle frame.
        send(2, 8'hFF, 1'b0, 8'h00, 0, f1);
        idle_check(2, 2);

        // tx_valid held: second start 177 cycles after the first.
        send(0, 8'h3C, 1'b1, 8'hC3, 0, f1);
        send(0, 8'hC3, 1'b0, 8'h00, 0, f2);
        check("b2b_start_spacing", f2 - f1, 177);
        idle_check(0, 2);

        // Reset during data bit 3 of 0x5A, then a clean frame.
        send(0, 8'h5A, 1'b0, 8'h00, 1 + 4 * 16 + 5, f1);
        idle_check(0, 4);
        send(0, 8'h81, 1'b0, 8'h00, 0, f1);
        idle_check(0, 1);

        send(3, 8'hA5, 1'b0, 8'h00, 0, f1);
        idle_check(3, 1);

        for (int k = 0; k < N_DUT; k++) begin
            b = 8'($urandom);
            for (int i = 0; i < 5; i++) begin
                kv = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
                nb = 8'($urandom);
                send(k, b, kv, nb, 0, f1);
                if (!kv) begin
                    idle_check(k, 1 + $urandom_range(0, 3));
                    b = 8'($urandom);
                end else begin
                    b = nb;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
